// File: rtl/scroll_sequencer.sv
// Scroll sequencer: once per accepted start, walks the four parallax layers
// through one shared advance unit (one layer per cycle), then commits all
// working LFSR/phase registers to the display-facing outputs in a single cycle.
//
// Handshake: a start request is taken only in IDLE; while busy is high any
// further start request is dropped and recorded in the sticky overrun flag.
// done pulses for exactly one cycle, in the cycle the committed outputs change.
module scroll_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        pause,
  input  logic        step_req,
  input  logic [7:0]  speed_cfg,
  output logic [35:0] layer_lfsr,
  output logic [11:0] layer_phase,
  output logic        busy,
  output logic        done,
  output logic        overrun,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [1:0]  r_idx;
  logic [1:0]  r_fdiv;
  logic [8:0]  r_lfsr [4];
  logic [2:0]  r_phase [4];
  logic [35:0] r_lfsr_c;
  logic [11:0] r_phase_c;
  logic        r_done;
  logic        r_overrun;

  logic        w_start;
  logic        w_busy;
  logic        w_scan;
  logic        w_commit;
  logic [1:0]  w_speed;
  logic        w_adv_en;
  logic [8:0]  w_cur_lfsr;
  logic [2:0]  w_cur_phase;
  logic [8:0]  w_next_lfsr;
  logic [2:0]  w_next_phase;

  // A tick and a step in the same cycle collapse into one start.
  assign w_start = (frame_tick & ~pause) | (step_req & pause);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic: IDLE -> SCAN (4 layers) -> COMMIT -> IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_next_state = S_SCAN;
      S_SCAN:   if (r_idx == 2'd3) w_next_state = S_COMMIT;
      S_COMMIT: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // FSM-derived control outputs.
  always_comb begin
    w_busy   = 1'b0;
    w_scan   = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      S_SCAN:   begin w_busy = 1'b1; w_scan = 1'b1; end
      S_COMMIT: begin w_busy = 1'b1; w_commit = 1'b1; end
      default:  ;
    endcase
  end

  // Layer index: cleared on start, stepped once per SCAN cycle.
  always_ff @(posedge clk) begin
    if (!rst_n)                           r_idx <= 2'd0;
    else if (r_state == S_IDLE && w_start) r_idx <= 2'd0;
    else if (w_scan)                      r_idx <= r_idx + 2'd1;
  end

  // Shared advance unit, operating on the layer selected by r_idx.
  always_comb begin
    w_cur_lfsr  = r_lfsr[r_idx];
    w_cur_phase = r_phase[r_idx];
    w_speed     = speed_cfg[{r_idx, 1'b0} +: 2];
    case (w_speed)
      2'd3:    w_adv_en = 1'b1;
      2'd2:    w_adv_en = ~r_fdiv[0];
      2'd1:    w_adv_en = (r_fdiv == 2'd0);
      default: w_adv_en = 1'b0;
    endcase
    w_next_phase = w_cur_phase + 3'd1;
    if (w_cur_phase == 3'd0)
      w_next_lfsr = {w_cur_lfsr[7:0], w_cur_lfsr[8] ^ w_cur_lfsr[4]};
    else
      w_next_lfsr = w_cur_lfsr;
  end

  // Working registers: only the scanned layer may change, and only if it advances.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_lfsr[i]  <= 9'h1FF;
        r_phase[i] <= 3'd7;
      end
    end else if (w_scan && w_adv_en) begin
      r_lfsr[r_idx]  <= w_next_lfsr;
      r_phase[r_idx] <= w_next_phase;
    end
  end

  // Commit: all four layers become visible together; frame divider steps here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lfsr_c  <= {4{9'h1FF}};
      r_phase_c <= {4{3'd7}};
      r_fdiv    <= 2'd0;
    end else if (w_commit) begin
      for (int i = 0; i < 4; i++) begin
        r_lfsr_c[9*i +: 9]  <= r_lfsr[i];
        r_phase_c[3*i +: 3] <= r_phase[i];
      end
      r_fdiv <= r_fdiv + 2'd1;
    end
  end

  // done marks the first cycle in which the new committed values are visible.
  always_ff @(posedge clk) begin
    if (!rst_n) r_done <= 1'b0;
    else        r_done <= w_commit;
  end

  // Sticky record of any start request that arrived while busy.
  always_ff @(posedge clk) begin
    if (!rst_n)                 r_overrun <= 1'b0;
    else if (w_start && w_busy) r_overrun <= 1'b1;
  end

  assign layer_lfsr  = r_lfsr_c;
  assign layer_phase = r_phase_c;
  assign busy        = w_busy;
  assign done        = r_done;
  assign overrun     = r_overrun;
  assign o_dbg_state = r_state;

endmodule
